// File: rtl/index_frame_decoder.sv
// Decodes a stream of encoded indices to a one-hot vector and folds each
// in_last-delimited frame into a request mask with beat count and duplicate flag.
module index_frame_decoder #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic                  in_last,
    output logic [(1<<IDX_W)-1:0] dec_onehot,
    output logic                  dec_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(1<<IDX_W)-1:0] out_mask,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_dup
);

    localparam int N = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               dup_reg, dup_next;
    logic [N-1:0]       dec_onehot_reg, dec_onehot_next;
    logic               dec_valid_reg, dec_valid_next;
    logic               out_valid_reg, out_valid_next;
    logic [N-1:0]       out_mask_reg, out_mask_next;
    logic [CNT_W-1:0]   out_count_reg, out_count_next;
    logic               out_dup_reg, out_dup_next;

    logic [N-1:0]       onehot;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit;
    logic               accept;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_decode
            assign onehot[gi] = (in_idx == IDX_W'(gi));
        end
    endgenerate

    assign in_ready = (state_reg == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;
    // Counter sticks at its maximum rather than wrapping.
    assign cnt_inc  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    assign hit      = |(acc_reg & onehot);

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        dup_next        = dup_reg;
        dec_onehot_next = dec_onehot_reg;
        dec_valid_next  = 1'b0;
        out_valid_next  = out_valid_reg;
        out_mask_next   = out_mask_reg;
        out_count_next  = out_count_reg;
        out_dup_next    = out_dup_reg;

        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    dec_onehot_next = onehot;
                    dec_valid_next  = 1'b1;
                    if (in_last) begin
                        // Frame closes: publish the result including this beat and start fresh.
                        out_mask_next  = acc_reg | onehot;
                        out_count_next = cnt_inc;
                        out_dup_next   = dup_reg | hit;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        cnt_next       = '0;
                        dup_next       = 1'b0;
                        state_next     = OUTPUT;
                    end else begin
                        acc_next = acc_reg | onehot;
                        cnt_next = cnt_inc;
                        dup_next = dup_reg | hit;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ACCUM;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            dup_reg        <= 1'b0;
            dec_onehot_reg <= '0;
            dec_valid_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_mask_reg   <= '0;
            out_count_reg  <= '0;
            out_dup_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            dup_reg        <= dup_next;
            dec_onehot_reg <= dec_onehot_next;
            dec_valid_reg  <= dec_valid_next;
            out_valid_reg  <= out_valid_next;
            out_mask_reg   <= out_mask_next;
            out_count_reg  <= out_count_next;
            out_dup_reg    <= out_dup_next;
        end
    end

    assign dec_onehot = dec_onehot_reg;
    assign dec_valid  = dec_valid_reg;
    assign out_valid  = out_valid_reg;
    assign out_mask   = out_mask_reg;
    assign out_count  = out_count_reg;
    assign out_dup    = out_dup_reg;

endmodule

// File: tb/tb_index_frame_decoder.sv
// Directed and randomized frames against a list-based model of each frame:
// mask is the OR of seen indices, count is the saturated list length, dup is any repeat.
module tb_index_frame_decoder;

    localparam int IDX_W = 2;
    localparam int CNT_W = 4;
    localparam int N     = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_last;
    logic [N-1:0]     dec_onehot;
    logic             dec_valid;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_mask;
    logic [CNT_W-1:0] out_count;
    logic             out_dup;

    index_frame_decoder #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_last    (in_last),
        .dec_onehot (dec_onehot),
        .dec_valid  (dec_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mask   (out_mask),
        .out_count  (out_count),
        .out_dup    (out_dup)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int frame[$];
    int exp_mask    = 0;
    int exp_count   = 0;
    int exp_dup     = 0;
    int exp_onehot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_mask"},  32'(out_mask),  32'(exp_mask));
        chk({tag, "_count"}, 32'(out_count), 32'(exp_count));
        chk({tag, "_dup"},   32'(out_dup),   32'(exp_dup));
    endtask

    // Reference for a completed frame, from the list of accepted indices.
    task automatic close_frame();
        int seen[N];
        exp_mask = 0;
        exp_dup  = 0;
        foreach (seen[k]) seen[k] = 0;
        foreach (frame[k]) begin
            exp_mask |= (1 << frame[k]);
            seen[frame[k]]++;
        end
        foreach (seen[k]) if (seen[k] > 1) exp_dup = 1;
        exp_count = (frame.size() > 15) ? 15 : frame.size();
        frame.delete();
    endtask

    task automatic beat(input int idx, input bit last);
        in_valid = 1'b1;
        in_idx   = IDX_W'(idx);
        in_last  = last;
        chk("in_ready_pre", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_idx   = IDX_W'($urandom);
        in_last  = 1'($urandom);
        exp_onehot = 1 << idx;
        frame.push_back(idx);
        chk("dec_valid", 32'(dec_valid), 32'd1);
        chk("dec_onehot", 32'(dec_onehot), 32'(exp_onehot));
        if (last) begin
            close_frame();
            chk("out_valid_set", 32'(out_valid), 32'd1);
            chk_result("result");
        end else begin
            chk("out_valid_low", 32'(out_valid), 32'd0);
            chk_result("held");
        end
        $display("beat idx=%0d last=%0d onehot=%b mask=%b count=%0d dup=%0d",
                 idx, last, dec_onehot, out_mask, out_count, out_dup);
    endtask

    // Stall the pending result for `hold` cycles with in_valid asserted, then handshake.
    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            in_idx    = IDX_W'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'b0;
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_dec_valid", 32'(dec_valid), 32'd0);
            chk("stall_onehot", 32'(dec_onehot), 32'(exp_onehot));
            chk_result("stall");
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("hs_valid", 32'(out_valid), 32'd0);
        chk("hs_ready", 32'(in_ready), 32'd1);
        chk("hs_dec_valid", 32'(dec_valid), 32'd0);
        chk_result("hs");
        $display("drain hold=%0d mask=%b count=%0d dup=%0d", hold, out_mask, out_count, out_dup);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_idx   = IDX_W'($urandom);
            in_last  = 1'($urandom);
            step();
            chk("idle_dec_valid", 32'(dec_valid), 32'd0);
            chk("idle_onehot", 32'(dec_onehot), 32'(exp_onehot));
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("rst_dec_valid", 32'(dec_valid), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_onehot", 32'(dec_onehot), 32'd0);
            chk("rst_mask", 32'(out_mask), 32'd0);
            chk("rst_count", 32'(out_count), 32'd0);
            chk("rst_dup", 32'(out_dup), 32'd0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        frame.delete();
        exp_mask = 0; exp_count = 0; exp_dup = 0; exp_onehot = 0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        $display("reset cycles=%0d", n);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;

        // Reset with in_valid high
        do_reset(2);

        // Single beat frame
        out_ready = 1'b1;
        beat(3, 1);
        drain(0);

        // Frame 1,2,0 with a 3-cycle stall
        beat(1, 0);
        beat(2, 0);
        beat(0, 1);
        drain(3);

        // Duplicate, then a clean frame
        beat(2, 0);
        beat(2, 1);
        drain(0);
        beat(1, 1);
        drain(0);

        // Counter saturation
        for (int i = 0; i < 16; i++) beat(0, 0);
        beat(0, 1);
        drain(1);

        // Reset mid-frame
        beat(3, 0);
        beat(1, 0);
        do_reset(1);
        beat(0, 1);
        drain(0);

        // Reset while a result is pending
        beat(2, 0);
        beat(3, 1);
        do_reset(1);
        idle(2);

        // Randomized frames
        for (int f = 0; f < 150; f++) begin
            int len;
            len = (f % 10 == 0) ? $urandom_range(14, 20) : $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                beat($urandom_range(0, N - 1), b == len - 1);
                if ($urandom_range(0, 3) == 0 && b != len - 1) idle($urandom_range(1, 2));
            end
            drain($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
